cic_dec_mc: RTL and testbench



---
 rtl/cic_dec_mc.sv | 187 ++++++++++++++++++
 tb/tb_cic_dec_mc.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cic_dec_mc.sv
// Multi-channel CIC decimator: per-channel integrators at the tick rate, one time-shared
// comb chain at the decimated rate, and a serialised, scaled and saturated output.
//
// state | meaning
// IDLE  | waiting for a decimated tick; a tick here takes the snapshot
// RUN   | evaluating the comb chain for channel idx, one channel per clock
module cic_dec_mc #(
    parameter int NUM_STAGES = 4,
    parameter int NUM_CH     = 2,
    parameter int MAX_DEC    = 32,
    parameter int W_IN       = 16,
    parameter int W_OUT      = 16,
    localparam int W_INT     = $clog2(MAX_DEC**NUM_STAGES) + W_IN,
    localparam int W_DEC     = $clog2(MAX_DEC + 1),
    localparam int W_SH      = $clog2(W_INT),
    localparam int W_CH      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     tick_i,
    input  logic [NUM_CH*W_IN-1:0]   signal_i,
    input  logic [W_DEC-1:0]         dec_i,
    input  logic [W_SH-1:0]          shift_i,
    output logic                     tick_dec_o,
    output logic                     valid_o,
    output logic [W_CH-1:0]          ch_o,
    output logic [W_OUT-1:0]         signal_o,
    output logic                     sat_o,
    output logic                     overrun_o
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    localparam logic signed [W_INT-1:0] OUT_MAX = {{(W_INT-W_OUT+1){1'b0}}, {(W_OUT-1){1'b1}}};
    localparam logic signed [W_INT-1:0] OUT_MIN = {{(W_INT-W_OUT+1){1'b1}}, {(W_OUT-1){1'b0}}};

    state_t                  state_q, state_d;
    logic [W_CH-1:0]         idx_q, idx_d;
    logic [W_DEC-1:0]        rate_q, cnt_q, rate_clamp;
    logic [W_SH-1:0]         shift_hold_q;

    logic signed [W_INT-1:0] integ_q [NUM_CH][NUM_STAGES];
    logic signed [W_INT-1:0] comb_q  [NUM_CH][NUM_STAGES];
    logic signed [W_INT-1:0] hold_q  [NUM_CH];
    logic signed [W_INT-1:0] in_ext  [NUM_CH];
    logic signed [W_INT-1:0] comb_in [NUM_STAGES+1];
    logic signed [W_INT-1:0] scaled;

    logic                    dec_tick, accept, running, last_ch;
    logic [W_OUT-1:0]        sig_d, sig_q;
    logic                    sat_d, sat_q;
    logic                    valid_q, overrun_q;
    logic [W_CH-1:0]         ch_q;

    always_comb begin
        rate_clamp = dec_i;
        if (dec_i == '0) begin
            rate_clamp = W_DEC'(1);
        end else if (dec_i > W_DEC'(MAX_DEC)) begin
            rate_clamp = W_DEC'(MAX_DEC);
        end
    end

    assign dec_tick   = tick_i && (cnt_q == (rate_q - W_DEC'(1)));
    assign running    = (state_q == S_RUN);
    assign accept     = dec_tick && !running;
    assign last_ch    = (idx_q == W_CH'(NUM_CH - 1));
    assign tick_dec_o = dec_tick && !rst_i;

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            in_ext[c] = {{(W_INT-W_IN){signal_i[c*W_IN+W_IN-1]}}, signal_i[c*W_IN +: W_IN]};
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_RUN;
                    idx_d   = '0;
                end
            end
            S_RUN: begin
                if (last_ch) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + W_CH'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Comb chain for the channel currently selected by idx; all stages wrap modulo 2^W_INT.
    always_comb begin
        comb_in[0] = hold_q[idx_q];
        for (int k = 0; k < NUM_STAGES; k++) begin
            comb_in[k+1] = comb_in[k] - comb_q[idx_q][k];
        end
        scaled = comb_in[NUM_STAGES] >>> shift_hold_q;
        sig_d  = scaled[W_OUT-1:0];
        sat_d  = 1'b0;
        if (scaled > OUT_MAX) begin
            sig_d = OUT_MAX[W_OUT-1:0];
            sat_d = 1'b1;
        end else if (scaled < OUT_MIN) begin
            sig_d = OUT_MIN[W_OUT-1:0];
            sat_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            rate_q       <= rate_clamp;
            shift_hold_q <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                hold_q[c] <= '0;
                for (int k = 0; k < NUM_STAGES; k++) begin
                    integ_q[c][k] <= '0;
                    comb_q[c][k]  <= '0;
                end
            end
            valid_q   <= 1'b0;
            ch_q      <= '0;
            sig_q     <= '0;
            sat_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;

            if (tick_i) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    integ_q[c][0] <= integ_q[c][0] + in_ext[c];
                    for (int k = 1; k < NUM_STAGES; k++) begin
                        integ_q[c][k] <= integ_q[c][k] + integ_q[c][k-1];
                    end
                end
                if (dec_tick) begin
                    cnt_q  <= '0;
                    rate_q <= rate_clamp;
                end else begin
                    cnt_q <= cnt_q + W_DEC'(1);
                end
            end

            // Snapshot takes the last integrator before this tick's update lands.
            if (accept) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    hold_q[c] <= integ_q[c][NUM_STAGES-1];
                end
                shift_hold_q <= shift_i;
            end

            if (running) begin
                for (int k = 0; k < NUM_STAGES; k++) begin
                    comb_q[idx_q][k] <= comb_in[k];
                end
                ch_q  <= idx_q;
                sig_q <= sig_d;
                sat_q <= sat_d;
            end
            valid_q <= running;

            if (dec_tick && running) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign valid_o   = valid_q;
    assign ch_o      = ch_q;
    assign signal_o  = sig_q;
    assign sat_o     = sat_q;
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_cic_dec_mc.sv
// Directed bench for cic_dec_mc (defaults: 4 stages, 2 channels, MAX_DEC 32, 16-bit in/out).
module tb_cic_dec_mc;

    logic        clk = 1'b0;
    logic        rst_i, tick_i;
    logic [31:0] signal_i;
    logic [5:0]  dec_i, shift_i;
    logic        tick_dec_o, valid_o, sat_o, overrun_o;
    logic [0:0]  ch_o;
    logic [15:0] signal_o;

    always #5 clk = ~clk;

    cic_dec_mc dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .tick_i     (tick_i),
        .signal_i   (signal_i),
        .dec_i      (dec_i),
        .shift_i    (shift_i),
        .tick_dec_o (tick_dec_o),
        .valid_o    (valid_o),
        .ch_o       (ch_o),
        .signal_o   (signal_o),
        .sat_o      (sat_o),
        .overrun_o  (overrun_o)
    );

    typedef struct {
        int dec; int sh; int a; int b; int n;
        int e0;  int e1; int sa; int sb;
    } vec_t;

    int   total = 0;
    int   bad   = 0;
    int   period = 3;
    int   phase  = 0;
    bit   tick_en = 0;
    int   o0 [32];
    int   o1 [32];
    bit   s0 [32];
    bit   s1 [32];
    int   n0, n1;
    vec_t vt [13];

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    // One clock: inputs change 1 ns after the rising edge, outputs are read at the falling edge.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (tick_en) begin
            tick_i = (phase == 0);
            phase  = (phase + 1) % period;
        end else begin
            tick_i = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input int dec, input int sh, input int a, input int b);
        tick_en  = 0;
        rst_i    = 1'b1;
        dec_i    = 6'(dec);
        shift_i  = 6'(sh);
        signal_i = {16'(b), 16'(a)};
        repeat (3) cyc();
        rst_i   = 1'b0;
        phase   = 0;
        tick_en = 1;
    endtask

    task automatic collect(input int n, input int budget);
        int sv;
        n0 = 0;
        n1 = 0;
        for (int i = 0; i < budget && n1 < n; i++) begin
            cyc();
            if (valid_o) begin
                sv = $signed(signal_o);
                if (ch_o == 1'b0 && n0 < 32) begin
                    o0[n0] = sv; s0[n0] = sat_o; n0++;
                end else if (ch_o == 1'b1 && n1 < 32) begin
                    o1[n1] = sv; s1[n1] = sat_o; n1++;
                end
            end
        end
        if (n1 < n) chk("collect_timeout", n1, n);
    endtask

    task automatic wait_dec(input int budget, input string nm);
        int i;
        for (i = 0; i < budget; i++) begin
            cyc();
            if (tick_dec_o) break;
        end
        if (i == budget) chk(nm, 0, 1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ticks, nd, cnt0;
        int iv [6];
        int exp_iv [6];
        int dc5 [5];

        rst_i = 1'b1; tick_i = 1'b0; signal_i = '0; dec_i = 6'd5; shift_i = '0;

        //            dec sh  a       b     n  e0      e1     sa sb
        vt[0]  = '{5,  0,  1,      1,    1, 1,      1,     0, 0};
        vt[1]  = '{5,  0,  1,      1,    2, 122,    122,   0, 0};
        vt[2]  = '{5,  0,  1,      1,    3, 503,    503,   0, 0};
        vt[3]  = '{5,  0,  1,      1,    4, 624,    624,   0, 0};
        vt[4]  = '{5,  0,  1,      1,    5, 625,    625,   0, 0};
        vt[5]  = '{5,  0,  1,     -1,    6, 625,   -625,   0, 0};
        vt[6]  = '{5,  0,  32767,  0,    6, 32767,  0,     1, 0};
        vt[7]  = '{5,  10, 32767,  0,    6, 19999,  0,     0, 0};
        vt[8]  = '{5,  0, -32768,  5,    6, -32768, 3125,  1, 0};
        vt[9]  = '{8,  0,  1,      1,    6, 4096,   4096,  0, 0};
        vt[10] = '{32, 0,  1,      0,    6, 32767,  0,     1, 0};
        vt[11] = '{1,  0,  100,   -3,    6, 100,   -3,     0, 0};
        vt[12] = '{5,  5,  1000,  -1000, 6, 19531, -19532, 0, 0};

        // reset state
        do_reset(5, 0, 1, 1);
        tick_en = 0;
        chk("rst_valid",   valid_o,    0);
        chk("rst_tickdec", tick_dec_o, 0);
        chk("rst_sat",     sat_o,      0);
        chk("rst_overrun", overrun_o,  0);
        chk("rst_ch",      ch_o,       0);
        chk("rst_signal",  signal_o,   0);

        // table: each vector starts from reset and checks the n-th output on both channels
        period = 3;
        for (int i = 0; i < 13; i++) begin
            do_reset(vt[i].dec, vt[i].sh, vt[i].a, vt[i].b);
            collect(vt[i].n, 2000);
            chk($sformatf("vec%0d_ch0", i), o0[vt[i].n-1], vt[i].e0);
            chk($sformatf("vec%0d_ch1", i), o1[vt[i].n-1], vt[i].e1);
            chk($sformatf("vec%0d_sat0", i), s0[vt[i].n-1], vt[i].sa);
            chk($sformatf("vec%0d_sat1", i), s1[vt[i].n-1], vt[i].sb);
        end

        // output pair timing: T+2 ch0, T+3 ch1, held afterwards
        do_reset(5, 0, 1, -1);
        wait_dec(100, "pair_no_tick");
        cyc(); chk("pair_t1_valid", valid_o, 0);
        cyc(); chk("pair_t2_valid", valid_o, 1); chk("pair_t2_ch", ch_o, 0);
        chk("pair_t2_sig", $signed(signal_o), 1);
        cyc(); chk("pair_t3_valid", valid_o, 1); chk("pair_t3_ch", ch_o, 1);
        chk("pair_t3_sig", $signed(signal_o), -1);
        cyc(); chk("pair_t4_valid", valid_o, 0); chk("pair_t4_ch", ch_o, 1);
        chk("pair_t4_hold", $signed(signal_o), -1);

        // rate clamp boundaries measured in input ticks to the first decimated tick
        exp_iv = '{1, 32, 0, 0, 0, 0};
        for (int j = 0; j < 2; j++) begin
            do_reset(j == 0 ? 0 : 63, 0, 1, 1);
            ticks = 0;
            for (int i = 0; i < 200; i++) begin
                cyc();
                if (tick_i) ticks++;
                if (tick_dec_o) break;
            end
            chk($sformatf("clamp%0d_ticks", j), ticks, exp_iv[j]);
        end

        // rate change 5 -> 8 in the middle of the third interval
        do_reset(5, 0, 1, 1);
        ticks = 0; nd = 0;
        for (int i = 0; i < 1000 && nd < 6; i++) begin
            cyc();
            if (tick_i) begin
                ticks++;
                if (tick_dec_o) begin
                    iv[nd] = ticks; nd++; ticks = 0;
                end
                if (nd == 2 && ticks == 2) dec_i = 6'd8;
            end
        end
        chk("ratechg_count", nd, 6);
        exp_iv = '{5, 5, 5, 8, 8, 8};
        for (int i = 0; i < 6; i++) chk($sformatf("ratechg_iv%0d", i), iv[i], exp_iv[i]);
        collect(5, 1000);
        chk("ratechg_ch0", o0[4], 4096);
        chk("ratechg_ch1", o1[4], 4096);

        // spacing of NUM_CH+1 clocks is safe, NUM_CH clocks overruns
        period = 3;
        do_reset(1, 0, 1, 1);
        repeat (30) cyc();
        chk("spacing3_overrun", overrun_o, 0);
        period = 2;
        do_reset(1, 0, 1, 1);
        repeat (10) cyc();
        chk("spacing2_overrun", overrun_o, 1);

        // tick every clock with rate 1: overrun within 2 clocks, sticky, cleared by reset
        period = 1;
        do_reset(1, 0, 1, 1);
        cyc();
        chk("ovr_first_tick", tick_dec_o, 1);
        cyc(); cyc();
        chk("ovr_rise", overrun_o, 1);
        cnt0 = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (!overrun_o) cnt0++;
        end
        chk("ovr_sticky", cnt0, 0);
        rst_i = 1'b1;
        cyc();
        chk("ovr_cleared", overrun_o, 0);
        chk("ovr_rst_tickdec", tick_dec_o, 0);
        tick_en = 0;
        rst_i = 1'b0;

        // reset the cycle after a decimated tick aborts the sequence
        period = 3;
        do_reset(5, 0, 1, 1);
        collect(1, 200);
        wait_dec(100, "abort_no_tick");
        cyc();
        rst_i = 1'b1;
        tick_en = 0;
        cnt0 = 0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (i == 1) rst_i = 1'b0;
            if (valid_o || signal_o != '0 || ch_o != '0 || sat_o || overrun_o) cnt0++;
        end
        chk("abort_quiet", cnt0, 0);
        phase = 0;
        tick_en = 1;
        collect(5, 1000);
        dc5 = '{1, 122, 503, 624, 625};
        for (int i = 0; i < 5; i++) chk($sformatf("abort_rerun%0d", i), o0[i], dc5[i]);
        chk("abort_rerun_ch1", o1[4], 625);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
